game_turn_ctrl: RTL

//  Parametrised turn/game controller for N-player, C-cell board games (tic-tac-toe by default).

---
 rtl/game_turn_if.sv | 44 ++++
 rtl/game_turn_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/game_turn_if.sv
// game_turn_if: bundle between the board/input datapath (master) and the
// turn controller (slave).
//   master drives : start, first_player, tick_en, move_valid, win_detect, new_game
//   slave drives  : state, active_player, move_ack, timeout_pulse, move_count,
//                   time_left, winner_valid, winner_id, scores
// Parameters must match those of the attached game_turn_ctrl.
interface game_turn_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int CELLS       = 9,
  parameter int TURN_TICKS  = 15,
  parameter int SCORE_W     = 4
);
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int CW = $clog2(CELLS + 1);
  localparam int TW = $clog2(TURN_TICKS + 1);

  logic                           start;
  logic [PW-1:0]                  first_player;
  logic                           tick_en;
  logic                           move_valid;
  logic                           win_detect;
  logic                           new_game;
  logic [2:0]                     state;
  logic [PW-1:0]                  active_player;
  logic                           move_ack;
  logic                           timeout_pulse;
  logic [CW-1:0]                  move_count;
  logic [TW-1:0]                  time_left;
  logic                           winner_valid;
  logic [PW-1:0]                  winner_id;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores;

  modport master (
    output start, first_player, tick_en, move_valid, win_detect, new_game,
    input  state, active_player, move_ack, timeout_pulse, move_count,
           time_left, winner_valid, winner_id, scores
  );

  modport slave (
    input  start, first_player, tick_en, move_valid, win_detect, new_game,
    output state, active_player, move_ack, timeout_pulse, move_count,
           time_left, winner_valid, winner_id, scores
  );
endinterface

// File: rtl/game_turn_ctrl.sv
// game_turn_ctrl: turn/round controller for N-player, C-cell board games.
// Rotates the active player, runs a per-turn tick countdown, counts moves,
// detects a full board, captures the winner and keeps saturating per-player
// scores across rounds (cleared only by reset).
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   bus  - game_turn_if.slave (datapath inputs, registered status outputs)
module game_turn_ctrl #(
  parameter int NUM_PLAYERS = 2,
  parameter int CELLS       = 9,
  parameter int TURN_TICKS  = 15,
  parameter int SCORE_W     = 4
) (
  input  logic        clk,
  input  logic        rst,
  game_turn_if.slave  bus
);
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int CW = $clog2(CELLS + 1);
  localparam int TW = $clog2(TURN_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_CHECK = 3'd2,
    S_WIN   = 3'd3,
    S_DRAW  = 3'd4
  } state_t;

  state_t                                st_q, st_nxt;
  logic [PW-1:0]                         player_q, winner_q;
  logic [PW-1:0]                         first_cl, player_adv;
  logic [CW-1:0]                         count_q;
  logic [TW-1:0]                         time_q;
  logic                                  ack_q, tmo_q, wvld_q;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0]   score_q;
  logic                                  expire, full, win_now;

  // Out-of-range first_player selects player 0.
  assign first_cl   = (int'(bus.first_player) >= NUM_PLAYERS) ? '0 : bus.first_player;
  assign player_adv = (int'(player_q) == NUM_PLAYERS - 1) ? '0 : player_q + 1'b1;
  assign expire     = bus.tick_en && (time_q == TW'(1));
  assign full       = (count_q == CW'(CELLS));
  // A win is only ever taken from CHECK and never in the same cycle as an abort.
  assign win_now    = (st_q == S_CHECK) && bus.win_detect && !bus.new_game;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st_q <= S_IDLE;
    else      st_q <= st_nxt;
  end

  always_comb begin
    st_nxt = st_q;
    if (bus.new_game) st_nxt = S_IDLE;
    else begin
      case (st_q)
        S_IDLE:  if (bus.start) st_nxt = S_PLAY;
        S_PLAY:  if (bus.move_valid) st_nxt = S_CHECK;
        S_CHECK: begin
          if (bus.win_detect) st_nxt = S_WIN;
          else if (full)      st_nxt = S_DRAW;
          else                st_nxt = S_PLAY;
        end
        S_WIN, S_DRAW: st_nxt = st_q;
        default: st_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      player_q <= '0;
      winner_q <= '0;
      count_q  <= '0;
      time_q   <= TW'(TURN_TICKS);
      ack_q    <= 1'b0;
      tmo_q    <= 1'b0;
      wvld_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      tmo_q <= 1'b0;
      if (bus.new_game) begin
        count_q <= '0;
        wvld_q  <= 1'b0;
        time_q  <= TW'(TURN_TICKS);
      end else begin
        case (st_q)
          S_IDLE: if (bus.start) begin
            player_q <= first_cl;
            time_q   <= TW'(TURN_TICKS);
            count_q  <= '0;
          end
          S_PLAY: begin
            // A move beats an expiring tick in the same cycle.
            if (bus.move_valid) begin
              count_q <= count_q + 1'b1;
              ack_q   <= 1'b1;
            end else if (expire) begin
              player_q <= player_adv;
              time_q   <= TW'(TURN_TICKS);
              tmo_q    <= 1'b1;
            end else if (bus.tick_en) begin
              time_q <= time_q - 1'b1;
            end
          end
          S_CHECK: begin
            if (bus.win_detect) begin
              wvld_q   <= 1'b1;
              winner_q <= player_q;
            end else if (!full) begin
              player_q <= player_adv;
              time_q   <= TW'(TURN_TICKS);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // One saturating score counter per player.
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_score
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) score_q[p] <= '0;
      else if (win_now && (int'(player_q) == p) && (score_q[p] != '1))
        score_q[p] <= score_q[p] + 1'b1;
    end
  end

  assign bus.state         = st_q;
  assign bus.active_player = player_q;
  assign bus.move_ack      = ack_q;
  assign bus.timeout_pulse = tmo_q;
  assign bus.move_count    = count_q;
  assign bus.time_left     = time_q;
  assign bus.winner_valid  = wvld_q;
  assign bus.winner_id     = winner_q;
  assign bus.scores        = score_q;
endmodule
